// File: rtl/branch_resolve_unit_pkg.sv
// rtl/branch_resolve_unit_pkg.sv - opcode/funct3 encodings and B-type decode helpers
package branch_resolve_unit_pkg;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] FNC_BEQ  = 3'b000;
  localparam logic [2:0] FNC_BNE  = 3'b001;
  localparam logic [2:0] FNC_BLT  = 3'b100;
  localparam logic [2:0] FNC_BGE  = 3'b101;
  localparam logic [2:0] FNC_BLTU = 3'b110;
  localparam logic [2:0] FNC_BGEU = 3'b111;

  // B-immediate field positions within the instruction word
  function automatic logic [12:0] b_imm(input logic [31:0] inst);
    return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic eq, input logic lt);
    logic t;
    t = 1'b0;
    case (f3)
      FNC_BEQ:            t = eq;
      FNC_BNE:            t = ~eq;
      FNC_BLT, FNC_BLTU:  t = lt;
      FNC_BGE, FNC_BGEU:  t = ~lt;
      default:            t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_comparator.sv
// rtl/branch_resolve_unit_comparator.sv - combinational rs1/rs2 equality and signed/unsigned less-than
module branch_comparator #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            brun_i,
  output logic            br_eq_o,
  output logic            br_lt_o
);

  assign br_eq_o = (rs1_i == rs2_i);
  assign br_lt_o = brun_i ? (rs1_i < rs2_i) : ($signed(rs1_i) < $signed(rs2_i));

endmodule

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - EX-stage branch resolve: stage register, redirect pulse, shadow squash, counters
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [31:0]      inst_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic [XLEN-1:0]  rs1_i,
  input  logic [XLEN-1:0]  rs2_i,
  input  logic             brun_i,
  input  logic             stall_i,
  input  logic             flush_i,
  output logic             redirect_valid_o,
  output logic [XLEN-1:0]  redirect_pc_o,
  output logic             taken_o,
  output logic             br_eq_o,
  output logic             br_lt_o,
  output logic             illegal_o,
  output logic             brun_err_o,
  output logic [CNT_W-1:0] branch_cnt_o,
  output logic [CNT_W-1:0] taken_cnt_o
);

  logic             eq_c, lt_c;
  logic             valid_q, taken_q, eq_q, lt_q, illegal_q, fired_q, err_q;
  logic [XLEN-1:0]  target_q;
  logic [CNT_W-1:0] branch_cnt_q, taken_cnt_q;

  logic [2:0]       f3;
  logic [12:0]      imm13;
  logic [XLEN-1:0]  imm_x, target_c;
  logic             redirect, live, taken_c, illegal_c, err_c;
  logic             unused_inst;

  branch_comparator #(.XLEN(XLEN)) u_cmp (
    .rs1_i   (rs1_i),
    .rs2_i   (rs2_i),
    .brun_i  (brun_i),
    .br_eq_o (eq_c),
    .br_lt_o (lt_c)
  );

  assign f3          = inst_i[14:12];
  assign imm13       = b_imm(inst_i);
  assign imm_x       = {{(XLEN-13){imm13[12]}}, imm13};
  assign target_c    = pc_i + imm_x;
  assign unused_inst = ^inst_i[24:15];

  // The redirect cycle doubles as the shadow: whatever fetch presents then is wrong-path.
  assign redirect  = valid_q & taken_q & ~fired_q;
  assign live      = valid_i & (inst_i[6:0] == OPC_BRANCH) & ~flush_i & ~redirect;
  assign illegal_c = (f3 == 3'b010) | (f3 == 3'b011);
  assign taken_c   = branch_taken(f3, eq_c, lt_c);
  assign err_c     = (((f3 == FNC_BLT)  | (f3 == FNC_BGE))  &  brun_i) |
                     (((f3 == FNC_BLTU) | (f3 == FNC_BGEU)) & ~brun_i);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      eq_q         <= 1'b0;
      lt_q         <= 1'b0;
      illegal_q    <= 1'b0;
      fired_q      <= 1'b0;
      err_q        <= 1'b0;
      target_q     <= '0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else if (stall_i) begin
      fired_q <= fired_q | redirect;
    end else begin
      fired_q   <= 1'b0;
      valid_q   <= live;
      taken_q   <= live & taken_c;
      eq_q      <= live & eq_c;
      lt_q      <= live & lt_c;
      illegal_q <= live & illegal_c;
      target_q  <= live ? target_c : '0;
      if (live) begin
        branch_cnt_q <= branch_cnt_q + CNT_W'(1);
        if (taken_c) taken_cnt_q <= taken_cnt_q + CNT_W'(1);
        if (err_c)   err_q       <= 1'b1;
      end
    end
  end

  assign redirect_valid_o = redirect;
  assign redirect_pc_o    = target_q;
  assign taken_o          = taken_q;
  assign br_eq_o          = eq_q;
  assign br_lt_o          = lt_q;
  assign illegal_o        = illegal_q;
  assign brun_err_o       = err_q;
  assign branch_cnt_o     = branch_cnt_q;
  assign taken_cnt_o      = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - directed and random checks of branch_resolve_unit against a behavioural model
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst, valid_i, brun_i, stall_i, flush_i;
  logic [31:0] inst_i, pc_i, rs1_i, rs2_i;
  logic        redirect_valid_o, taken_o, br_eq_o, br_lt_o, illegal_o, brun_err_o;
  logic [31:0] redirect_pc_o, branch_cnt_o, taken_cnt_o;

  int n_assert = 0;
  int n_fail   = 0;

  // behavioural model of the architectural state
  logic        m_valid, m_taken, m_eq, m_lt, m_ill, m_fired, m_err;
  logic [31:0] m_tgt, m_bcnt, m_tcnt;
  logic [31:0] saved;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk              (clk),
    .rst              (rst),
    .valid_i          (valid_i),
    .inst_i           (inst_i),
    .pc_i             (pc_i),
    .rs1_i            (rs1_i),
    .rs2_i            (rs2_i),
    .brun_i           (brun_i),
    .stall_i          (stall_i),
    .flush_i          (flush_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .taken_o          (taken_o),
    .br_eq_o          (br_eq_o),
    .br_lt_o          (br_lt_o),
    .illegal_o        (illegal_o),
    .brun_err_o       (brun_err_o),
    .branch_cnt_o     (branch_cnt_o),
    .taken_cnt_o      (taken_cnt_o)
  );

  function automatic logic [31:0] mk_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("redirect_valid", {31'd0, redirect_valid_o}, {31'd0, m_valid & m_taken & ~m_fired});
    chk("redirect_pc",    redirect_pc_o, m_tgt);
    chk("taken",          {31'd0, taken_o},    {31'd0, m_taken});
    chk("br_eq",          {31'd0, br_eq_o},    {31'd0, m_eq});
    chk("br_lt",          {31'd0, br_lt_o},    {31'd0, m_lt});
    chk("illegal",        {31'd0, illegal_o},  {31'd0, m_ill});
    chk("brun_err",       {31'd0, brun_err_o}, {31'd0, m_err});
    chk("branch_cnt",     branch_cnt_o, m_bcnt);
    chk("taken_cnt",      taken_cnt_o,  m_tcnt);
  endtask

  // Next-state of the model from the inputs currently applied
  task automatic model_step();
    logic redir, live, eq, lt, tk;
    logic [2:0] f3;
    redir = m_valid & m_taken & ~m_fired;
    f3 = inst_i[14:12];
    if (!rst) begin
      {m_valid, m_taken, m_eq, m_lt, m_ill, m_fired, m_err} = '0;
      m_tgt = 0; m_bcnt = 0; m_tcnt = 0;
    end else if (stall_i) begin
      if (redir) m_fired = 1'b1;
    end else begin
      live = valid_i && inst_i[6:0] == 7'h63 && !flush_i && !redir;
      eq = (rs1_i == rs2_i);
      lt = brun_i ? (rs1_i < rs2_i) : ($signed(rs1_i) < $signed(rs2_i));
      case (f3)
        3'd0: tk = eq;
        3'd1: tk = !eq;
        3'd4, 3'd6: tk = lt;
        3'd5, 3'd7: tk = !lt;
        default: tk = 1'b0;
      endcase
      m_fired = 1'b0;
      m_valid = live;
      m_taken = live && tk;
      m_eq    = live && eq;
      m_lt    = live && lt;
      m_ill   = live && (f3 == 3'd2 || f3 == 3'd3);
      m_tgt   = live ? pc_i + {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0} : 32'd0;
      if (live) begin
        m_bcnt++;
        if (tk) m_tcnt++;
        if (((f3 == 3'd4 || f3 == 3'd5) && brun_i) || ((f3 == 3'd6 || f3 == 3'd7) && !brun_i)) m_err = 1'b1;
      end
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic present(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                         input logic [31:0] b, input logic brun);
    valid_i = 1'b1; inst_i = inst; pc_i = pc; rs1_i = a; rs2_i = b; brun_i = brun;
  endtask

  task automatic idle();
    valid_i = 1'b0; inst_i = 32'h0000_0013;
  endtask

  initial begin
    {m_valid, m_taken, m_eq, m_lt, m_ill, m_fired, m_err} = '0;
    m_tgt = 0; m_bcnt = 0; m_tcnt = 0;
    rst = 1'b0; valid_i = 1'b0; inst_i = 0; pc_i = 0; rs1_i = 0; rs2_i = 0;
    brun_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
    cycle();
    chk("reset_redirect", {31'd0, redirect_valid_o}, 32'd0);
    chk("reset_bcnt", branch_cnt_o, 32'd0);
    rst = 1'b1;

    // 1: taken BEQ, +8 from 0x100
    present(mk_b(3'b000, 13'd8), 32'h100, 32'd5, 32'd5, 1'b0);
    cycle();
    chk("t1_pc", redirect_pc_o, 32'h108);
    chk("t1_redir", {31'd0, redirect_valid_o}, 32'd1);
    chk("t1_cnt", {branch_cnt_o[15:0], taken_cnt_o[15:0]}, {16'd1, 16'd1});
    idle(); cycle();
    chk("t1_pulse_end", {31'd0, redirect_valid_o}, 32'd0);

    // 2: signed vs unsigned less-than
    present(mk_b(3'b100, 13'h1FF0), 32'h200, 32'hFFFF_FFFF, 32'd1, 1'b0);
    cycle();
    chk("t2_blt_taken", {31'd0, taken_o}, 32'd1);
    idle(); cycle();
    present(mk_b(3'b110, 13'd16), 32'h300, 32'hFFFF_FFFF, 32'd1, 1'b1);
    cycle();
    chk("t2_bltu_taken", {31'd0, taken_o}, 32'd0);
    chk("t2_bltu_lt", {31'd0, br_lt_o}, 32'd0);

    // 3: taken BNE held by a 3-cycle stall
    present(mk_b(3'b001, 13'd12), 32'h400, 32'd1, 32'd2, 1'b0);
    cycle();
    saved = branch_cnt_o;
    idle(); stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t3_no_repeat", {31'd0, redirect_valid_o}, 32'd0);
      chk("t3_cnt_hold", branch_cnt_o, saved);
    end
    stall_i = 1'b0;
    cycle();

    // 4: BEQ on the redirect cycle is squashed
    present(mk_b(3'b101, 13'd4), 32'h500, 32'd3, 32'd3, 1'b0);
    cycle();
    saved = branch_cnt_o;
    present(mk_b(3'b000, 13'd4), 32'h504, 32'd7, 32'd7, 1'b0);
    cycle();
    chk("t4_squash_cnt", branch_cnt_o, saved);

    // 5: flush kills capture; flush under stall is ignored
    present(mk_b(3'b111, 13'd8), 32'h600, 32'd9, 32'd1, 1'b1);
    flush_i = 1'b1;
    cycle();
    chk("t5_flush_redir", {31'd0, redirect_valid_o}, 32'd0);
    chk("t5_flush_cnt", branch_cnt_o, saved);
    flush_i = 1'b0;
    present(mk_b(3'b000, 13'd8), 32'h700, 32'd1, 32'd2, 1'b0);
    cycle();
    present(mk_b(3'b111, 13'd8), 32'h704, 32'd9, 32'd1, 1'b1);
    stall_i = 1'b1; flush_i = 1'b1;
    cycle();
    chk("t5_stall_hold_lt", {31'd0, br_lt_o}, 32'd1);
    stall_i = 1'b0; flush_i = 1'b0;

    // 6: illegal funct3, sticky brun error, reset on a redirect cycle
    present({17'd0, 3'b010, 5'd0, 7'b1100011}, 32'h800, 32'd1, 32'd1, 1'b0);
    cycle();
    chk("t6_illegal", {30'd0, illegal_o, taken_o}, 32'd2);
    present(mk_b(3'b110, 13'd8), 32'h900, 32'd5, 32'd1, 1'b0);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_err_sticky", {31'd0, brun_err_o}, 32'd1);
    end
    present(mk_b(3'b000, 13'd8), 32'hA00, 32'd4, 32'd4, 1'b0);
    cycle();
    idle(); rst = 1'b0;
    cycle();
    chk("t6_reset_redir", {31'd0, redirect_valid_o}, 32'd0);
    chk("t6_reset_err", {31'd0, brun_err_o}, 32'd0);
    rst = 1'b1;
    cycle();
    chk("t6_no_pulse_after", {31'd0, redirect_valid_o}, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 9) != 0);
      inst_i  = $urandom;
      if ($urandom_range(0, 4) != 0) inst_i[6:0] = 7'b1100011;
      pc_i    = $urandom;
      rs1_i   = $urandom;
      case ($urandom_range(0, 3))
        0: rs2_i = rs1_i;
        1: rs2_i = $urandom_range(0, 4);
        default: rs2_i = $urandom;
      endcase
      if ($urandom_range(0, 3) == 0) rs1_i = $urandom_range(0, 4) - 2;
      brun_i  = $urandom_range(0, 1);
      stall_i = ($urandom_range(0, 4) == 0);
      flush_i = ($urandom_range(0, 7) == 0);
      rst     = ($urandom_range(0, 59) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
